// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO write producer and read consumer.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  // Occupancy of the producer's 2-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL2 = 2'd2
  } prod_state_t;

endpackage

// File: rtl/producer_skid_buf.sv
// Two-entry in-order skid buffer; the occupancy FSM and the storage share one next-state block.
module producer_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head,
  output prod_state_t           state
);

  prod_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q,  head_d;
  logic [DATA_WIDTH-1:0] ent1_q,  ent1_d;

  // Next occupancy and storage; head reads zero whenever the buffer is empty.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    ent1_d  = ent1_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          ent1_d  = push_data;
          state_d = FULL2;
        end else if (pop) begin
          head_d  = '0;
          state_d = EMPTY;
        end
      end
      FULL2: begin
        if (pop) begin
          head_d  = ent1_q;
          ent1_d  = '0;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
        head_d  = '0;
        ent1_d  = '0;
      end
    endcase
  end

  // State and storage registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      ent1_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      ent1_q  <= ent1_d;
    end
  end

  assign head  = head_q;
  assign state = state_q;

endmodule

// File: rtl/fifo_write_producer.sv
// Write-side front end of the dual-clock FIFO: upstream handshake, memory write gating and debug counters.
module fifo_write_producer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  w_clk,
  input  logic                  wrst_n,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  wr_ready,
  input  logic                  f_full,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic                  drop_err
);

  prod_state_t           state;
  logic [DATA_WIDTH-1:0] head;
  logic                  push;
  logic                  pop;

  logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;
  logic                  drop_err_q, drop_err_d;

  // Ready depends on registered occupancy only, so f_full never reaches upstream combinationally.
  assign wr_ready = (state != FULL2);
  assign w_en     = (state != EMPTY) & ~f_full;
  assign push     = wr_req & wr_ready;
  assign pop      = w_en;

  producer_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (w_clk),
    .rst_n     (wrst_n),
    .push      (push),
    .pop       (pop),
    .push_data (data_in),
    .head      (head),
    .state     (state)
  );

  // Committed-write counter (wrapping) and sticky drop flag.
  always_comb begin
    wr_count_d = wr_count_q;
    drop_err_d = drop_err_q;
    if (pop) begin
      wr_count_d = wr_count_q + CNT_WIDTH'(1);
    end
    if (wr_req && !wr_ready) begin
      drop_err_d = 1'b1;
    end
  end

  // Debug registers, cleared asynchronously.
  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      wr_count_q <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wr_count_q <= wr_count_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign mem_data_in = head;
  assign wr_count    = wr_count_q;
  assign drop_err    = drop_err_q;

endmodule
